// File: rtl/sfx_arbiter.sv
// Priority scheduler that shares one audio output path between NUM_REQ tone sources.
// Optional macro AUDIO_SFX_PREEMPT_EN lets a higher-priority request cut off the playing tone.
module sfx_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] AMPLITUDE = 32'd5000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [16*NUM_REQ-1:0]      req_half_period,
  input  logic [16*NUM_REQ-1:0]      req_duration,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         preempted,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  input  logic                       audio_out_allowed,
  output logic                       write_audio_out,
  output logic [31:0]                left_channel_audio_out,
  output logic [31:0]                right_channel_audio_out
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;
  localparam logic [31:0] NEG_AMPLITUDE = ~AMPLITUDE + 32'd1;

  logic [0:0]         state_q, state_d;
  logic [IDW-1:0]     active_q, active_d;
  logic [15:0]        half_q, half_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [15:0]        phase_q, phase_d;
  logic               pol_q, pol_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] pre_q, pre_d;
  logic [31:0]        sample_q, sample_d;

  int             g;
  logic [IDW-1:0] g_idx;
  logic           req_any;
  logic           wr;

  // Lowest set request index wins.
  always_comb begin
    g = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) g = i;
    end
    g_idx   = IDW'(g);
    req_any = |req;
  end

  assign wr = audio_out_allowed;

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    half_d      = half_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    pol_d       = pol_q;
    ack_d       = '0;
    done_d      = '0;
    pre_d       = '0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d     = PLAY;
          active_d    = g_idx;
          half_d      = req_half_period[g*16 +: 16];
          remaining_d = req_duration[g*16 +: 16];
          phase_d     = '0;
          pol_d       = 1'b1;
          ack_d[g]    = 1'b1;
        end
      end
      default: begin
        // A zero-length tone finishes right after its grant, write or not.
        if (remaining_q == 16'd0 || (wr && remaining_q == 16'd1)) begin
          done_d[active_q] = 1'b1;
          state_d          = IDLE;
          active_d         = '0;
          remaining_d      = '0;
        end else begin
`ifdef AUDIO_SFX_PREEMPT_EN
          if (req_any && g_idx < active_q) begin
            pre_d[active_q] = 1'b1;
            active_d        = g_idx;
            half_d          = req_half_period[g*16 +: 16];
            remaining_d     = req_duration[g*16 +: 16];
            phase_d         = '0;
            pol_d           = 1'b1;
            ack_d[g]        = 1'b1;
          end else
`endif
          if (wr) begin
            remaining_d = remaining_q - 16'd1;
            if (half_q != 16'd0 && phase_q == half_q - 16'd1) begin
              phase_d = '0;
              pol_d   = ~pol_q;
            end else begin
              phase_d = phase_q + 16'd1;
            end
          end
        end
      end
    endcase
  end

  // The sample register holds what the next cycle presents to the codec.
  always_comb begin
    sample_d = '0;
    if (state_d == PLAY && half_d != 16'd0 && remaining_d != 16'd0)
      sample_d = pol_d ? AMPLITUDE : NEG_AMPLITUDE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      active_q    <= '0;
      half_q      <= '0;
      remaining_q <= '0;
      phase_q     <= '0;
      pol_q       <= 1'b0;
      ack_q       <= '0;
      done_q      <= '0;
      pre_q       <= '0;
      sample_q    <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      half_q      <= half_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      pol_q       <= pol_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      pre_q       <= pre_d;
      sample_q    <= sample_d;
    end
  end

  assign req_ack                 = ack_q;
  assign req_done                = done_q;
  assign preempted               = pre_q;
  assign busy                    = (state_q == PLAY);
  assign active_id               = active_q;
  assign write_audio_out         = audio_out_allowed;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter: cycle-by-cycle vector table plus preemption and reset sequences.
module tb_sfx_arbiter;
  localparam logic [31:0] A  = 32'd5000000;
  localparam logic [31:0] NA = 32'hFFB3B4C0; // -5000000

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_half_period;
  logic [63:0] req_duration;
  logic [3:0]  req_ack, req_done, preempted;
  logic        busy;
  logic [1:0]  active_id;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;

  int errors = 0;
  int checks = 0;

  sfx_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .req_half_period(req_half_period), .req_duration(req_duration),
    .req_ack(req_ack), .req_done(req_done), .preempted(preempted),
    .busy(busy), .active_id(active_id),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] hp;
    logic [15:0] dur;
    logic        allow;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  act;
    logic [31:0] left;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [3:0] r, logic [15:0] hp, logic [15:0] dur, logic al,
                              logic [3:0] ack, logic [3:0] done, logic b, logic [1:0] act,
                              logic [31:0] left);
    vec_t v;
    v.req = r; v.hp = hp; v.dur = dur; v.allow = al;
    v.ack = ack; v.done = done; v.busy = b; v.act = act; v.left = left;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(logic [3:0] r, logic [15:0] hp, logic [15:0] dur, logic al);
    req               = r;
    req_half_period   = {4{hp}};
    req_duration      = {4{dur}};
    audio_out_allowed = al;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [3:0] ack, logic [3:0] done, logic [3:0] pre,
                         logic b, logic [1:0] act, logic [31:0] left);
    chk({tag, ".ack"}, 32'(req_ack), 32'(ack));
    chk({tag, ".done"}, 32'(req_done), 32'(done));
    chk({tag, ".pre"}, 32'(preempted), 32'(pre));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".act"}, 32'(active_id), 32'(act));
    chk({tag, ".left"}, left_channel_audio_out, left);
    chk({tag, ".right"}, right_channel_audio_out, left);
  endtask

  initial begin
    reset = 1'b1;
    drive(4'd0, 16'd0, 16'd0, 1'b1);
    step();
    chk_all("reset", 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0);
    step();
    reset = 1'b0;

    // Idle silence
    vq.push_back(mk(4'd0, 16'd0, 16'd0, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0));
    vq.push_back(mk(4'd0, 16'd0, 16'd0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0));
    vq.push_back(mk(4'd0, 16'd0, 16'd0, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0));
    // req[2], half period 3, duration 12
    vq.push_back(mk(4'd4, 16'd3, 16'd12, 1'b1, 4'd4, 4'd0, 1'b1, 2'd2, A));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, A));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, A));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, NA));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, NA));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, NA));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, A));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, A));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, A));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, NA));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, NA));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, NA));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd4, 1'b0, 2'd0, 32'd0));
    vq.push_back(mk(4'd0, 16'd3, 16'd12, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0));
    // Stalled tone: req[1], half period 2, duration 4, allowed toggling
    vq.push_back(mk(4'd2, 16'd2, 16'd4, 1'b1, 4'd2, 4'd0, 1'b1, 2'd1, A));
    vq.push_back(mk(4'd0, 16'd2, 16'd4, 1'b1, 4'd0, 4'd0, 1'b1, 2'd1, A));
    vq.push_back(mk(4'd0, 16'd2, 16'd4, 1'b0, 4'd0, 4'd0, 1'b1, 2'd1, A));
    vq.push_back(mk(4'd0, 16'd2, 16'd4, 1'b1, 4'd0, 4'd0, 1'b1, 2'd1, NA));
    vq.push_back(mk(4'd0, 16'd2, 16'd4, 1'b0, 4'd0, 4'd0, 1'b1, 2'd1, NA));
    vq.push_back(mk(4'd0, 16'd2, 16'd4, 1'b1, 4'd0, 4'd0, 1'b1, 2'd1, NA));
    vq.push_back(mk(4'd0, 16'd2, 16'd4, 1'b0, 4'd0, 4'd0, 1'b1, 2'd1, NA));
    vq.push_back(mk(4'd0, 16'd2, 16'd4, 1'b1, 4'd0, 4'd2, 1'b0, 2'd0, 32'd0));
    // req[0] and req[3] together, half period 1, duration 2
    vq.push_back(mk(4'd9, 16'd1, 16'd2, 1'b1, 4'd1, 4'd0, 1'b1, 2'd0, A));
    vq.push_back(mk(4'd8, 16'd1, 16'd2, 1'b1, 4'd0, 4'd0, 1'b1, 2'd0, NA));
    vq.push_back(mk(4'd8, 16'd1, 16'd2, 1'b1, 4'd0, 4'd1, 1'b0, 2'd0, 32'd0));
    vq.push_back(mk(4'd8, 16'd1, 16'd2, 1'b1, 4'd8, 4'd0, 1'b1, 2'd3, A));
    vq.push_back(mk(4'd0, 16'd1, 16'd2, 1'b1, 4'd0, 4'd0, 1'b1, 2'd3, NA));
    vq.push_back(mk(4'd0, 16'd1, 16'd2, 1'b1, 4'd0, 4'd8, 1'b0, 2'd0, 32'd0));
    // Duration 0 on req[1]
    vq.push_back(mk(4'd2, 16'd5, 16'd0, 1'b1, 4'd2, 4'd0, 1'b1, 2'd1, 32'd0));
    vq.push_back(mk(4'd0, 16'd5, 16'd0, 1'b1, 4'd0, 4'd2, 1'b0, 2'd0, 32'd0));
    // Rest (half period 0) on req[2], duration 2
    vq.push_back(mk(4'd4, 16'd0, 16'd2, 1'b1, 4'd4, 4'd0, 1'b1, 2'd2, 32'd0));
    vq.push_back(mk(4'd0, 16'd0, 16'd2, 1'b1, 4'd0, 4'd0, 1'b1, 2'd2, 32'd0));
    vq.push_back(mk(4'd0, 16'd0, 16'd2, 1'b1, 4'd0, 4'd4, 1'b0, 2'd0, 32'd0));

    foreach (vq[k]) begin
      drive(vq[k].req, vq[k].hp, vq[k].dur, vq[k].allow);
      #1;
      chk($sformatf("v%0d.write", k), 32'(write_audio_out), 32'(vq[k].allow));
      step();
      chk_all($sformatf("v%0d", k), vq[k].ack, vq[k].done, 4'd0, vq[k].busy, vq[k].act, vq[k].left);
    end

    // Preemption: req[3] playing (half period 4, duration 12) with 10 remaining when req[1] rises
    drive(4'd8, 16'd4, 16'd12, 1'b1); step();
    chk_all("pre.grant3", 4'd8, 4'd0, 4'd0, 1'b1, 2'd3, A);
    drive(4'd0, 16'd4, 16'd12, 1'b1); step(); step();
    chk_all("pre.rem10", 4'd0, 4'd0, 4'd0, 1'b1, 2'd3, A);
    drive(4'd2, 16'd4, 16'd3, 1'b1); step();
`ifdef AUDIO_SFX_PREEMPT_EN
    chk_all("pre.cut", 4'd2, 4'd0, 4'd8, 1'b1, 2'd1, A);
    drive(4'd0, 16'd4, 16'd3, 1'b1); step();
    chk_all("pre.new1", 4'd0, 4'd0, 4'd0, 1'b1, 2'd1, A);
    step();
    chk_all("pre.new2", 4'd0, 4'd0, 4'd0, 1'b1, 2'd1, A);
    step();
    chk_all("pre.done1", 4'd0, 4'd2, 4'd0, 1'b0, 2'd0, 32'd0);
`else
    chk_all("nopre.wait0", 4'd0, 4'd0, 4'd0, 1'b1, 2'd3, A);
    for (int c = 1; c < 9; c++) begin
      step();
      chk($sformatf("nopre.wait%0d.ack", c), 32'(req_ack), 32'd0);
      chk($sformatf("nopre.wait%0d.pre", c), 32'(preempted), 32'd0);
    end
    step();
    chk_all("nopre.done3", 4'd0, 4'd8, 4'd0, 1'b0, 2'd0, 32'd0);
    step();
    chk_all("nopre.ack1", 4'd2, 4'd0, 4'd0, 1'b1, 2'd1, A);
    drive(4'd0, 16'd4, 16'd3, 1'b1); step(); step(); step();
    chk_all("nopre.done1", 4'd0, 4'd2, 4'd0, 1'b0, 2'd0, 32'd0);
`endif

    // Reset in the middle of a tone
    drive(4'd1, 16'd2, 16'd50, 1'b1); step();
    chk_all("rst.grant0", 4'd1, 4'd0, 4'd0, 1'b1, 2'd0, A);
    drive(4'd0, 16'd2, 16'd50, 1'b1); step(); step(); step();
    chk("rst.playing", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_all("rst.async", 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_all($sformatf("rst.after%0d", c), 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0);
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sfx_arbiter.md
# sfx_arbiter

Priority scheduler that shares the single Audio_Controller output path between up to NUM_REQ sound sources (melody player, slice/bomb/combo effects). Each source requests a square-wave tone given as half-period and duration in samples. The block grants one source at a time, synthesises its samples, and feeds the codec FIFO through the write_audio_out / audio_out_allowed handshake. When no source is active it writes silence so the DAC stream never starves.

## Interface
- NUM_REQ, 4: number of requesters; index 0 is highest priority.
- AMPLITUDE, 32'd5000000: tone magnitude; samples are +AMPLITUDE or -AMPLITUDE, in 32-bit two's complement.
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per source, held until req_ack.
- req_half_period  in  16*NUM_REQ  flattened; slice i = bits [16i+15:16i]; half-period in samples; 0 = rest (silence).
- req_duration  in  16*NUM_REQ  flattened, same slicing; tone length in samples.
- req_ack  out  NUM_REQ  one-cycle pulse when source i is granted.
- req_done  out  NUM_REQ  one-cycle pulse when source i's tone completes naturally.
- preempted  out  NUM_REQ  one-cycle pulse when source i's tone is cut off by a higher-priority grant.
- busy  out  1  high in PLAY.
- active_id  out  $clog2(NUM_REQ)  index of the granted source; 0 when idle.
- audio_out_allowed  in  1  Audio_Controller FIFO has space.
- write_audio_out  out  1  equals audio_out_allowed (combinational).
- left_channel_audio_out  out  32  current sample.
- right_channel_audio_out  out  32  identical to left.

## Operation
- Reset values:
  - All pulses and busy are 0; active_id is 0; state is IDLE.
  - Channel outputs are 0. Phase counter, remaining count and polarity are 0.
- A sample is consumed in each cycle with write_audio_out=1. All counters advance only on such cycles.
- IDLE:
  - Channel outputs are 0.
  - If any req bit is set, grant the lowest set index g. Latch its half-period and duration, set phase=0 and polarity=1 (positive), pulse req_ack[g], then go to PLAY.
  - If the latched duration is 0, pulse req_done[g] on the next cycle and return to IDLE. No tone sample is emitted.
- PLAY:
  - Channel output = polarity ? AMPLITUDE : -AMPLITUDE. If the latched half-period is 0, the output is 0 and polarity is held.
  - On each write: remaining decrements.
  - If half-period is nonzero and phase == half_period-1, phase goes to 0 and polarity toggles; otherwise phase increments.
  - A write with remaining == 1 completes the tone: req_done[active] pulses, and the next state is IDLE.
- Preemption:
  - Applies in a PLAY cycle that is not completing, when req has a set bit below active_id.
  - preempted[old] and req_ack[new] pulse together. New parameters are latched, phase=0, polarity=1, and the block stays in PLAY.
- Completion in the same cycle as a higher-priority req: completion wins. The request is granted from IDLE one cycle later.
- A requester whose req stays high after ack is treated as a new request. The requester must drop req on ack; the block does not filter this.
- Same-index or lower-priority requests during PLAY wait. There is no self-preemption.

## Timing
- Grant latency: req high in IDLE at cycle t gives req_ack, busy and active_id at t+1.
- The first tone sample is visible on the channel outputs at t+1 and is consumed at the first write at or after t+1.
- Duration D ≥ 1 consumes exactly D tone samples.
- req_done pulses in the cycle after the D-th write. The channel outputs return to 0 in that same cycle.
- Tone period is 2*half_period samples. At 48 kHz, half_period 91 gives ≈263.7 Hz.
- Preemption takes effect on the cycle after the higher-priority req is sampled.
- Asserting reset in mid-tone aborts immediately to reset values. No done or preempted pulse is generated.
- All outputs except write_audio_out are registered.

## Configuration
- AUDIO_SFX_PREEMPT_EN defined: preemption works as described above.
- AUDIO_SFX_PREEMPT_EN undefined:
  - Strictly non-preemptive; preempted is tied to 0.
  - Higher-priority requests wait until req_done, then are arbitrated from IDLE.

## Test plan
- Reset, then hold audio_out_allowed=1 with no req: outputs stay 0, write_audio_out=1, busy=0, all pulses 0.
- req[2] with half_period 3 and duration 12, allowed=1: ack[2] at t+1. Samples are +A,+A,+A,-A,-A,-A repeated twice. done[2] pulses after the 12th write, and the outputs return to 0.
- Toggle allowed as 1,0,1,0 during a tone of duration 4: 4 tone samples are consumed over 8 cycles, and phase holds in the stall cycles.
- req[0] and req[3] asserted together in IDLE: ack[0] only. After done[0], ack[3] follows one cycle later.
- Macro on, req[3] playing with remaining 10 when req[1] rises: preempted[3] and ack[1] pulse in the same cycle, and the output restarts at +A. Macro off: no preempt, and ack[1] comes only after done[3].
- Duration 0 on req[1], then reset asserted mid-tone on a second request:
  - Duration-0 request: ack[1] then done[1] on consecutive cycles, with no nonzero sample.
  - Reset mid-tone: everything returns to 0 at once, with no done pulse.
